// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating counters and a registered prediction.
// Define BTB_UPDATE_BYPASS_EN to forward a same-cycle table update into the lookup.
module btb_predictor #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 64
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_stall,
  input  logic            i_flush,
  input  logic            i_fetch_valid,
  input  logic [XLEN-1:0] i_fetch_pc,
  input  logic            i_update_valid,
  input  logic [XLEN-1:0] i_update_pc,
  input  logic [XLEN-1:0] i_update_target,
  input  logic            i_update_taken,
  input  logic            i_update_is_jump,
  output logic            o_prediction_used_r,
  output logic [XLEN-1:0] o_predicted_target_r
);

  localparam int IDX = $clog2(ENTRIES);
  localparam int TAG = XLEN - IDX - 2;

  logic            valid_q  [ENTRIES];
  logic            valid_d  [ENTRIES];
  logic [1:0]      ctr_q    [ENTRIES];
  logic [1:0]      ctr_d    [ENTRIES];
  logic [TAG-1:0]  tag_q    [ENTRIES];
  logic [TAG-1:0]  tag_d    [ENTRIES];
  logic [XLEN-1:0] target_q [ENTRIES];
  logic [XLEN-1:0] target_d [ENTRIES];

  logic            pred_used_q, pred_used_d;
  logic [XLEN-1:0] pred_target_q, pred_target_d;

  logic [IDX-1:0]  upd_idx, f_idx;
  logic [TAG-1:0]  upd_tag, f_tag;
  logic            upd_hit, upd_we;
  logic [1:0]      upd_ctr;
  logic [XLEN-1:0] upd_target;

  logic            lk_valid, lk_hit, lk_used;
  logic [TAG-1:0]  lk_tag;
  logic [1:0]      lk_ctr;
  logic [XLEN-1:0] lk_target;

  // Byte-offset bit 0 never participates in indexing, tagging or alignment checks.
  logic unused_lsb;
  assign unused_lsb = i_fetch_pc[0] ^ i_update_pc[0];

  assign upd_idx = i_update_pc[IDX+1:2];
  assign upd_tag = i_update_pc[XLEN-1:IDX+2];
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign upd_we  = i_update_valid && !i_update_pc[1] && (upd_hit || i_update_taken);

  always_comb begin
    upd_ctr = ctr_q[upd_idx];
    if (i_update_taken && i_update_is_jump) begin
      upd_ctr = 2'b11;
    end else if (!upd_hit) begin
      upd_ctr = 2'b10;
    end else if (i_update_taken) begin
      upd_ctr = (ctr_q[upd_idx] == 2'b11) ? 2'b11 : ctr_q[upd_idx] + 2'd1;
    end else begin
      upd_ctr = (ctr_q[upd_idx] == 2'b00) ? 2'b00 : ctr_q[upd_idx] - 2'd1;
    end
    upd_target = i_update_taken ? i_update_target : target_q[upd_idx];
  end

  always_comb begin
    valid_d  = valid_q;
    ctr_d    = ctr_q;
    tag_d    = tag_q;
    target_d = target_q;
    if (upd_we) begin
      valid_d[upd_idx]  = 1'b1;
      ctr_d[upd_idx]    = upd_ctr;
      tag_d[upd_idx]    = upd_tag;
      target_d[upd_idx] = upd_target;
    end
  end

  assign f_idx = i_fetch_pc[IDX+1:2];
  assign f_tag = i_fetch_pc[XLEN-1:IDX+2];

  // Reading the next-state arrays gives the post-update entry for free.
`ifdef BTB_UPDATE_BYPASS_EN
  assign lk_valid  = valid_d[f_idx];
  assign lk_tag    = tag_d[f_idx];
  assign lk_ctr    = ctr_d[f_idx];
  assign lk_target = target_d[f_idx];
`else
  assign lk_valid  = valid_q[f_idx];
  assign lk_tag    = tag_q[f_idx];
  assign lk_ctr    = ctr_q[f_idx];
  assign lk_target = target_q[f_idx];
`endif

  assign lk_hit  = i_fetch_valid && lk_valid && (lk_tag == f_tag) && !i_fetch_pc[1];
  assign lk_used = lk_hit && lk_ctr[1];

  always_comb begin
    pred_used_d   = pred_used_q;
    pred_target_d = pred_target_q;
    if (i_flush) begin
      pred_used_d   = 1'b0;
      pred_target_d = '0;
    end else if (!i_stall) begin
      pred_used_d   = lk_used;
      pred_target_d = lk_used ? lk_target : '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= '0;
      end
      pred_used_q   <= 1'b0;
      pred_target_q <= '0;
    end else begin
      valid_q       <= valid_d;
      ctr_q         <= ctr_d;
      pred_used_q   <= pred_used_d;
      pred_target_q <= pred_target_d;
    end
  end

  // Payload is qualified by valid, so it carries no reset.
  always_ff @(posedge i_clk) begin
    tag_q    <= tag_d;
    target_q <= target_d;
  end

  assign o_prediction_used_r  = pred_used_q;
  assign o_predicted_target_r = pred_target_q;

endmodule

// File: tb/tb_btb_predictor.sv
// Self-checking bench for btb_predictor: directed vector table, hand sequences, random vs. reference model.
module tb_btb_predictor;

  localparam int ENTRIES = 64;
  localparam int IB      = $clog2(ENTRIES);

  logic        clk = 1'b0;
  logic        rst, stall, flush, fv, uv, ut, uj;
  logic [31:0] fpc, upc, utgt;
  logic        o_used;
  logic [31:0] o_tgt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  btb_predictor #(.XLEN(32), .ENTRIES(ENTRIES)) dut (
    .i_clk                (clk),
    .i_reset              (rst),
    .i_stall              (stall),
    .i_flush              (flush),
    .i_fetch_valid        (fv),
    .i_fetch_pc           (fpc),
    .i_update_valid       (uv),
    .i_update_pc          (upc),
    .i_update_target      (utgt),
    .i_update_taken       (ut),
    .i_update_is_jump     (uj),
    .o_prediction_used_r  (o_used),
    .o_predicted_target_r (o_tgt)
  );

  typedef struct {
    string       name;
    bit          rst, stall, flush, fv;
    logic [31:0] fpc;
    bit          uv;
    logic [31:0] upc, utgt;
    bit          ut, uj;
    bit          eu;
    logic [31:0] et;
  } vec_t;

  // Reference model: one record per index, counter as a plain integer.
  bit          m_valid [ENTRIES];
  logic [31:0] m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  bit          exp_used;
  logic [31:0] exp_tgt;

  function automatic vec_t mk(string n, bit r, bit s, bit f, bit v, logic [31:0] p, bit u,
                              logic [31:0] up, logic [31:0] t, bit tk, bit j, bit eu, logic [31:0] et);
    vec_t x;
    x.name = n; x.rst = r; x.stall = s; x.flush = f; x.fv = v; x.fpc = p;
    x.uv = u; x.upc = up; x.utgt = t; x.ut = tk; x.uj = j; x.eu = eu; x.et = et;
    return x;
  endfunction

  function automatic vec_t F(string n, logic [31:0] p, bit eu, logic [31:0] et);
    return mk(n, 0, 0, 0, 1, p, 0, 0, 0, 0, 0, eu, et);
  endfunction

  function automatic vec_t U(string n, logic [31:0] up, logic [31:0] t, bit tk, bit j, bit eu, logic [31:0] et);
    return mk(n, 0, 0, 0, 0, 0, 1, up, t, tk, j, eu, et);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0;
      m_ctr[i]   = 0;
    end
    exp_used = 0;
    exp_tgt  = '0;
  endtask

  task automatic model_update(input vec_t v);
    int          idx;
    logic [31:0] tg;
    bit          hit;
    if (!v.uv || v.upc[1]) return;
    idx = int'((v.upc >> 2) % ENTRIES);
    tg  = v.upc >> (IB + 2);
    hit = m_valid[idx] && (m_tag[idx] == tg);
    if (hit) begin
      if (v.ut) begin
        m_ctr[idx] = v.uj ? 3 : ((m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3);
        m_tgt[idx] = v.utgt;
      end else begin
        m_ctr[idx] = (m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0;
      end
    end else if (v.ut) begin
      m_valid[idx] = 1;
      m_tag[idx]   = tg;
      m_tgt[idx]   = v.utgt;
      m_ctr[idx]   = v.uj ? 3 : 2;
    end
  endtask

  task automatic model_step(input vec_t v);
    int          idx;
    bit          used;
    logic [31:0] t;
    if (v.rst) begin
      model_reset();
      return;
    end
`ifdef BTB_UPDATE_BYPASS_EN
    model_update(v);
`endif
    idx  = int'((v.fpc >> 2) % ENTRIES);
    used = v.fv && !v.fpc[1] && m_valid[idx] && (m_tag[idx] == (v.fpc >> (IB + 2))) && (m_ctr[idx] >= 2);
    t    = m_tgt[idx];
`ifndef BTB_UPDATE_BYPASS_EN
    model_update(v);
`endif
    if (v.flush) begin
      exp_used = 0;
      exp_tgt  = '0;
    end else if (!v.stall) begin
      exp_used = used;
      exp_tgt  = used ? t : '0;
    end
  endtask

  task automatic check(input string name, input bit eu, input logic [31:0] et);
    n_vec++;
    if (o_used !== eu || o_tgt !== et) begin
      n_err++;
      $display("FAIL %s: got used=%0b target=%08h, expected used=%0b target=%08h",
               name, o_used, o_tgt, eu, et);
    end
  endtask

  // Drives one cycle; compares against the vector's constants or against the model.
  task automatic apply(input vec_t v, input bit vs_model);
    rst = v.rst; stall = v.stall; flush = v.flush; fv = v.fv; fpc = v.fpc;
    uv = v.uv; upc = v.upc; utgt = v.utgt; ut = v.ut; uj = v.uj;
    model_step(v);
    @(posedge clk);
    #1;
    if (vs_model) check(v.name, exp_used, exp_tgt);
    else          check(v.name, v.eu, v.et);
  endtask

  function automatic logic [31:0] rpc();
    logic [31:0] p;
    p = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 2) |
        ($urandom_range(0, 1) << 1) | $urandom_range(0, 1);
    return p;
  endfunction

  vec_t tbl[$];
  vec_t rv;
  bit   byp_used;
  logic [31:0] byp_tgt;

  initial begin
    rst = 1; stall = 0; flush = 0; fv = 0; fpc = '0; uv = 0; upc = '0; utgt = '0; ut = 0; uj = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 1'b0, 32'h0);
    rst = 0;

    tbl.push_back(F("lookup_empty",      32'h1000, 0, 32'h0));
    tbl.push_back(U("alloc_taken",       32'h1000, 32'h2000, 1, 0, 0, 32'h0));
    tbl.push_back(F("hit_ctr2",          32'h1000, 1, 32'h2000));
    tbl.push_back(U("nt_ctr1",           32'h1000, 32'h0, 0, 0, 0, 32'h0));
    tbl.push_back(F("hit_ctr1",          32'h1000, 0, 32'h0));
    tbl.push_back(U("nt_ctr0",           32'h1000, 32'h0, 0, 0, 0, 32'h0));
    tbl.push_back(U("nt_sat0",           32'h1000, 32'h0, 0, 0, 0, 32'h0));
    tbl.push_back(U("tk_ctr1",           32'h1000, 32'h2000, 1, 0, 0, 32'h0));
    tbl.push_back(F("no_wrap_at0",       32'h1000, 0, 32'h0));
    tbl.push_back(U("tk_ctr2_newtgt",    32'h1000, 32'h3000, 1, 0, 0, 32'h0));
    tbl.push_back(F("hit_newtgt",        32'h1000, 1, 32'h3000));
    tbl.push_back(U("half_upd_ignored",  32'h1002, 32'h4000, 1, 0, 0, 32'h0));
    tbl.push_back(F("half_lookup",       32'h1002, 0, 32'h0));
    tbl.push_back(F("full_after_half",   32'h1000, 1, 32'h3000));
    tbl.push_back(F("tag_miss",          32'h1100, 0, 32'h0));
    tbl.push_back(U("jump_overwrite",    32'h5000, 32'h6000, 1, 1, 0, 32'h0));
    tbl.push_back(F("jump_hit",          32'h5000, 1, 32'h6000));
    tbl.push_back(F("evicted_miss",      32'h1000, 0, 32'h0));
    tbl.push_back(U("jump_nt_ctr2",      32'h5000, 32'h0, 0, 0, 0, 32'h0));
    tbl.push_back(F("jump_ctr_was3",     32'h5000, 1, 32'h6000));
    tbl.push_back(mk("fetch_invalid", 0, 0, 0, 0, 32'h5000, 0, 0, 0, 0, 0, 0, 32'h0));
    tbl.push_back(mk("upd_other_idx", 0, 0, 0, 1, 32'h5000, 1, 32'h2004, 32'h7000, 1, 0, 1, 32'h6000));
    tbl.push_back(F("other_idx_hit",     32'h2004, 1, 32'h7000));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], 0);

    // Stall hold, table update under stall, then flush overriding stall.
    apply(F("pre_stall", 32'h5000, 1, 32'h6000), 0);
    apply(mk("stall1", 0, 1, 0, 1, 32'h1000, 0, 0, 0, 0, 0, 1, 32'h6000), 0);
    apply(mk("stall2_upd", 0, 1, 0, 1, 32'h1000, 1, 32'h5000, 32'h6100, 1, 0, 1, 32'h6000), 0);
    apply(mk("stall3", 0, 1, 0, 1, 32'h1000, 0, 0, 0, 0, 0, 1, 32'h6000), 0);
    apply(mk("flush_in_stall", 0, 1, 1, 1, 32'h5000, 0, 0, 0, 0, 0, 0, 32'h0), 0);
    apply(F("after_flush", 32'h5000, 1, 32'h6100), 0);

    // Reset with an update pending empties the table; then same-cycle update/lookup.
    apply(mk("reset_mid", 1, 0, 0, 1, 32'h5000, 1, 32'h1008, 32'h9000, 1, 0, 0, 32'h0), 0);
    apply(F("post_reset_upd", 32'h1008, 0, 32'h0), 0);
    apply(F("post_reset_old", 32'h5000, 0, 32'h0), 0);
`ifdef BTB_UPDATE_BYPASS_EN
    byp_used = 1; byp_tgt = 32'h2000;
`else
    byp_used = 0; byp_tgt = 32'h0;
`endif
    apply(mk("same_cycle", 0, 0, 0, 1, 32'h1000, 1, 32'h1000, 32'h2000, 1, 0, byp_used, byp_tgt), 0);
    apply(F("next_cycle", 32'h1000, 1, 32'h2000), 0);

    for (int n = 0; n < 3000; n++) begin
      rv = mk("random", $urandom_range(0, 199) == 0, $urandom_range(0, 5) == 0,
              $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0, rpc(),
              $urandom_range(0, 1) == 1, rpc(), $urandom, $urandom_range(0, 2) != 0,
              $urandom_range(0, 3) == 0, 0, 32'h0);
      apply(rv, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
